// File: rtl/sprite_renderer_scaled.sv
// Scaled sprite renderer: fetches one sprite line from a byte-wide ROM into a line buffer,
// then shifts it out on gfx with optional mirroring and 2x horizontal/vertical scaling.
module sprite_renderer_scaled #(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vstart,
  input  logic          load,
  input  logic          hstart,
  input  logic          hmirror,
  input  logic          vmirror,
  input  logic          xscale,
  input  logic          yscale,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_bits,
  output logic          gfx,
  output logic          busy,
  output logic          frame_done
);

  localparam int BW  = SPR_W / 8;
  localparam int LBW = $clog2(BW);
  localparam int BIW = (LBW > 0) ? LBW : 1;
  localparam int RW  = $clog2(SPR_H);
  localparam int XW  = $clog2(SPR_W);

  localparam logic [BIW-1:0] B_LAST = BIW'(BW - 1);
  localparam logic [RW-1:0]  R_LAST = RW'(SPR_H - 1);
  localparam logic [XW-1:0]  X_LAST = XW'(SPR_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOAD,
    FETCH_SETUP,
    FETCH_CAPTURE,
    WAIT_HSTART,
    DRAW
  } state_t;

  state_t state, next_state;

  logic             hm, vm, xs, ys;
  logic             ysub, xsub;
  logic [RW-1:0]    row;
  logic [BIW-1:0]   byte_index;
  logic [XW-1:0]    xcount;
  logic [SPR_W-1:0] linebuf;
  logic [XW-1:0]    px;
  logic             last_byte, line_end, last_row;

  assign last_byte = (byte_index == B_LAST);
  assign line_end  = (xcount == X_LAST) && (!xs || xsub);
  assign last_row  = (row == R_LAST);
  assign px        = hm ? (X_LAST - xcount) : xcount;
  assign busy      = (state != IDLE);

  // Row field is vertically mirrored before being packed above the byte index.
  function automatic logic [AW-1:0] fetch_addr(input logic mir, input logic [RW-1:0] r,
                                               input logic [BIW-1:0] b);
    logic [RW-1:0] eff;
    eff = mir ? (R_LAST - r) : r;
    return (AW'(eff) << LBW) | AW'(b);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:          if (vstart) next_state = WAIT_LOAD;
      WAIT_LOAD:     if (load) next_state = FETCH_SETUP;
      FETCH_SETUP:   next_state = FETCH_CAPTURE;
      FETCH_CAPTURE: next_state = last_byte ? WAIT_HSTART : FETCH_SETUP;
      WAIT_HSTART:   if (hstart) next_state = DRAW;
      DRAW: begin
        if (line_end) begin
          if (ys && !ysub) next_state = WAIT_LOAD;
          else             next_state = last_row ? IDLE : WAIT_LOAD;
        end
      end
      default:       next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hm         <= 1'b0;
      vm         <= 1'b0;
      xs         <= 1'b0;
      ys         <= 1'b0;
      ysub       <= 1'b0;
      xsub       <= 1'b0;
      row        <= '0;
      byte_index <= '0;
      xcount     <= '0;
      linebuf    <= '0;
      rom_addr   <= '0;
      gfx        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      gfx        <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (vstart) begin
            hm   <= hmirror;
            vm   <= vmirror;
            xs   <= xscale;
            ys   <= yscale;
            row  <= '0;
            ysub <= 1'b0;
          end
        end
        WAIT_LOAD: begin
          byte_index <= '0;
          xcount     <= '0;
          xsub       <= 1'b0;
          if (load) rom_addr <= fetch_addr(vm, row, '0);
        end
        FETCH_CAPTURE: begin
          for (int b = 0; b < BW; b++) begin
            if (byte_index == BIW'(b)) linebuf[8*b +: 8] <= rom_bits;
          end
          if (!last_byte) begin
            byte_index <= byte_index + BIW'(1);
            rom_addr   <= fetch_addr(vm, row, byte_index + BIW'(1));
          end
        end
        DRAW: begin
          gfx  <= linebuf[px];
          xsub <= xs ? ~xsub : 1'b0;
          if (!xs || xsub) xcount <= xcount + XW'(1);
          // With vertical doubling the first pass of a row re-fetches the same row.
          if (line_end) begin
            if (ys && !ysub) begin
              ysub <= 1'b1;
            end else begin
              ysub <= 1'b0;
              row  <= row + RW'(1);
              if (last_row) frame_done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_renderer_scaled.sv
// Directed bench for sprite_renderer_scaled: default 16x16 instance plus a 32x8 instance
// for the wide-sprite fetch sequence.
module tb_sprite_renderer_scaled;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       vstart = 1'b0, load = 1'b0, hstart = 1'b0;
  logic       hmirror = 1'b0, vmirror = 1'b0, xscale = 1'b0, yscale = 1'b0;
  logic [4:0] rom_addr;
  logic [7:0] rom_bits;
  logic       gfx, busy, frame_done;

  logic       w_vstart = 1'b0, w_load = 1'b0, w_hstart = 1'b0;
  logic [4:0] w_rom_addr;
  logic [7:0] w_rom_bits;
  logic       w_gfx, w_busy, w_frame_done;

  logic [7:0] rom  [32];
  logic [7:0] rom2 [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_bits   <= rom[rom_addr];
  always @(posedge clk) w_rom_bits <= rom2[w_rom_addr];

  sprite_renderer_scaled #(.SPR_W(16), .SPR_H(16), .AW(5)) dut (
    .clk(clk), .reset_n(reset_n), .vstart(vstart), .load(load), .hstart(hstart),
    .hmirror(hmirror), .vmirror(vmirror), .xscale(xscale), .yscale(yscale),
    .rom_addr(rom_addr), .rom_bits(rom_bits), .gfx(gfx), .busy(busy),
    .frame_done(frame_done)
  );

  sprite_renderer_scaled #(.SPR_W(32), .SPR_H(8), .AW(5)) dut_wide (
    .clk(clk), .reset_n(reset_n), .vstart(w_vstart), .load(w_load), .hstart(w_hstart),
    .hmirror(1'b0), .vmirror(1'b0), .xscale(1'b0), .yscale(1'b0),
    .rom_addr(w_rom_addr), .rom_bits(w_rom_bits), .gfx(w_gfx), .busy(w_busy),
    .frame_done(w_frame_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] word16(input int r);
    return {rom[2*r+1], rom[2*r]};
  endfunction

  function automatic logic [31:0] expect_line(input logic [15:0] word, input bit mir, input bit dbl);
    logic [31:0] e;
    int n;
    e = '0;
    n = dbl ? 32 : 16;
    for (int i = 0; i < n; i++) begin
      int p;
      p = dbl ? i / 2 : i;
      e[i] = word[mir ? 15 - p : p];
    end
    return e;
  endfunction

  // Runs one scanline from WAIT_LOAD: load, two fetch pairs, hstart, then records gfx per cycle.
  task automatic do_line(input bit dbl, output logic [31:0] seen, output logic [4:0] a0,
                         output logic [4:0] a1, output logic pre, output logic fd_end,
                         output logic busy_end, output logic fd_early);
    int n;
    n = dbl ? 32 : 16;
    load = 1'b1; step(); load = 1'b0;
    a0 = rom_addr;
    step(); step();
    a1 = rom_addr;
    step(); step();
    hstart = 1'b1; step(); hstart = 1'b0;
    pre = gfx;
    seen = '0;
    fd_early = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      seen[i] = gfx;
      if (i < n - 1) fd_early = fd_early | frame_done;
    end
    fd_end   = frame_done;
    busy_end = busy;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    checks++; if (gfx !== 1'b0) begin errors++; $display("[TB] FAIL reset_gfx got %b want 0", gfx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done got %b want 0", frame_done); end
    checks++; if (rom_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_rom_addr got %0d want 0", rom_addr); end
    step(); step();
    reset_n = 1'b1;
    step();
    load = 1'b1; hstart = 1'b1; step(); load = 1'b0; hstart = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_ignores_load busy got %b want 0", busy); end
    checks++; if (gfx !== 1'b0) begin errors++; $display("[TB] FAIL idle_gfx got %b want 0", gfx); end
  endtask

  task automatic test_basic();
    logic [31:0] seen, exp;
    logic [4:0] a0, a1;
    logic pre, fde, be, fdx;
    for (int i = 0; i < 32; i++) rom[i] = 8'(i * 37 + 5);
    rom[0] = 8'h07; rom[1] = 8'h00;
    vstart = 1'b1; step(); vstart = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_start got %b want 1", busy); end
    for (int r = 0; r < 16; r++) begin
      if (r == 3) begin vstart = 1'b1; step(); vstart = 1'b0; end
      do_line(1'b0, seen, a0, a1, pre, fde, be, fdx);
      exp = (r == 0) ? 32'h0000_0007 : expect_line(word16(r), 1'b0, 1'b0);
      checks++; if (a0 !== 5'(2*r)) begin errors++; $display("[TB] FAIL basic_addr0 row %0d got %0d want %0d", r, a0, 2*r); end
      checks++; if (a1 !== 5'(2*r+1)) begin errors++; $display("[TB] FAIL basic_addr1 row %0d got %0d want %0d", r, a1, 2*r+1); end
      checks++; if (seen !== exp) begin errors++; $display("[TB] FAIL basic_pixels row %0d got %h want %h", r, seen, exp); end
      checks++; if (pre !== 1'b0) begin errors++; $display("[TB] FAIL basic_first_draw_gfx row %0d got %b want 0", r, pre); end
      checks++; if (fde !== (r == 15)) begin errors++; $display("[TB] FAIL basic_frame_done row %0d got %b want %b", r, fde, r == 15); end
      checks++; if (fdx !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_frame_done row %0d got %b want 0", r, fdx); end
      checks++; if (be !== (r != 15)) begin errors++; $display("[TB] FAIL basic_busy_end row %0d got %b want %b", r, be, r != 15); end
      if (r == 0) begin
        step();
        checks++; if (gfx !== 1'b0) begin errors++; $display("[TB] FAIL basic_gfx_after_line got %b want 0", gfx); end
      end
    end
    step();
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL basic_frame_done_pulse got %b want 0", frame_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_idle got %b want 0", busy); end
  endtask

  task automatic test_hmirror();
    logic [31:0] seen, exp;
    logic [4:0] a0, a1;
    logic pre, fde, be, fdx;
    hmirror = 1'b1;
    vstart = 1'b1; step(); vstart = 1'b0;
    hmirror = 1'b0;
    for (int r = 0; r < 16; r++) begin
      if (r == 2) hmirror = 1'b1;
      if (r == 4) hmirror = 1'b0;
      do_line(1'b0, seen, a0, a1, pre, fde, be, fdx);
      exp = (r == 0) ? 32'h0000_E000 : expect_line(word16(r), 1'b1, 1'b0);
      checks++; if (seen !== exp) begin errors++; $display("[TB] FAIL hmirror_pixels row %0d got %h want %h", r, seen, exp); end
      checks++; if (fde !== (r == 15)) begin errors++; $display("[TB] FAIL hmirror_frame_done row %0d got %b want %b", r, fde, r == 15); end
    end
  endtask

  task automatic test_vmirror_yscale();
    logic [31:0] seen, exp;
    logic [4:0] a0, a1;
    logic pre, fde, be, fdx;
    int row;
    vmirror = 1'b1; yscale = 1'b1;
    vstart = 1'b1; step(); vstart = 1'b0;
    vmirror = 1'b0; yscale = 1'b0;
    for (int l = 0; l < 32; l++) begin
      row = l / 2;
      do_line(1'b0, seen, a0, a1, pre, fde, be, fdx);
      exp = expect_line(word16(15 - row), 1'b0, 1'b0);
      checks++; if (a0 !== 5'((15-row)*2)) begin errors++; $display("[TB] FAIL vmirror_addr0 line %0d got %0d want %0d", l, a0, (15-row)*2); end
      checks++; if (a1 !== 5'((15-row)*2+1)) begin errors++; $display("[TB] FAIL vmirror_addr1 line %0d got %0d want %0d", l, a1, (15-row)*2+1); end
      checks++; if (seen !== exp) begin errors++; $display("[TB] FAIL vmirror_pixels line %0d got %h want %h", l, seen, exp); end
      checks++; if (fde !== (l == 31)) begin errors++; $display("[TB] FAIL yscale_frame_done line %0d got %b want %b", l, fde, l == 31); end
      checks++; if (fdx !== 1'b0) begin errors++; $display("[TB] FAIL yscale_early_frame_done line %0d got %b want 0", l, fdx); end
    end
  endtask

  task automatic test_xscale();
    logic [31:0] seen;
    logic [4:0] a0, a1;
    logic pre, fde, be, fdx;
    for (int i = 0; i < 32; i++) rom[i] = 8'hAA;
    xscale = 1'b1;
    vstart = 1'b1; step(); vstart = 1'b0;
    xscale = 1'b0;
    for (int r = 0; r < 16; r++) begin
      do_line(1'b1, seen, a0, a1, pre, fde, be, fdx);
      checks++; if (seen !== 32'hCCCC_CCCC) begin errors++; $display("[TB] FAIL xscale_pixels row %0d got %h want cccccccc", r, seen); end
      checks++; if (be !== (r != 15)) begin errors++; $display("[TB] FAIL xscale_busy row %0d got %b want %b", r, be, r != 15); end
      checks++; if (fde !== (r == 15)) begin errors++; $display("[TB] FAIL xscale_frame_done row %0d got %b want %b", r, fde, r == 15); end
    end
  endtask

  task automatic test_reset_mid_draw();
    logic [31:0] seen;
    logic [4:0] a0, a1;
    logic pre, fde, be, fdx;
    for (int i = 0; i < 32; i++) rom[i] = 8'(i * 37 + 5);
    rom[0] = 8'h07; rom[1] = 8'h00;
    rom[10] = 8'hFF; rom[11] = 8'hFF;
    vstart = 1'b1; step(); vstart = 1'b0;
    for (int r = 0; r < 5; r++) do_line(1'b0, seen, a0, a1, pre, fde, be, fdx);
    load = 1'b1; step(); load = 1'b0;
    checks++; if (rom_addr !== 5'd10) begin errors++; $display("[TB] FAIL midreset_row5_addr got %0d want 10", rom_addr); end
    step(); step(); step(); step();
    hstart = 1'b1; step(); hstart = 1'b0;
    step();
    checks++; if (gfx !== 1'b1) begin errors++; $display("[TB] FAIL midreset_drawing got %b want 1", gfx); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (gfx !== 1'b0) begin errors++; $display("[TB] FAIL midreset_gfx got %b want 0", gfx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %b want 0", busy); end
    checks++; if (rom_addr !== 5'd0) begin errors++; $display("[TB] FAIL midreset_rom_addr got %0d want 0", rom_addr); end
    step();
    reset_n = 1'b1;
    step();
    load = 1'b1; step(); load = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_waits_vstart got %b want 0", busy); end
    vstart = 1'b1; step(); vstart = 1'b0;
    do_line(1'b0, seen, a0, a1, pre, fde, be, fdx);
    checks++; if (a0 !== 5'd0) begin errors++; $display("[TB] FAIL midreset_restart_addr got %0d want 0", a0); end
    checks++; if (seen !== 32'h0000_0007) begin errors++; $display("[TB] FAIL midreset_restart_pixels got %h want 00000007", seen); end
    reset_n = 1'b0; step(); step(); reset_n = 1'b1; step();
  endtask

  task automatic test_wide();
    logic [31:0] wseen, exp;
    for (int i = 0; i < 32; i++) rom2[i] = 8'(i * 29 + 3);
    w_vstart = 1'b1; step(); w_vstart = 1'b0;
    for (int r = 0; r < 8; r++) begin
      w_load = 1'b1; step(); w_load = 1'b0;
      for (int k = 0; k < 4; k++) begin
        checks++; if (w_rom_addr !== 5'(r*4+k)) begin errors++; $display("[TB] FAIL wide_addr row %0d byte %0d got %0d want %0d", r, k, w_rom_addr, r*4+k); end
        step(); step();
      end
      w_hstart = 1'b1; step(); w_hstart = 1'b0;
      for (int i = 0; i < 32; i++) begin
        step();
        wseen[i] = w_gfx;
      end
      exp = {rom2[4*r+3], rom2[4*r+2], rom2[4*r+1], rom2[4*r]};
      checks++; if (wseen !== exp) begin errors++; $display("[TB] FAIL wide_pixels row %0d got %h want %h", r, wseen, exp); end
      checks++; if (w_frame_done !== (r == 7)) begin errors++; $display("[TB] FAIL wide_frame_done row %0d got %b want %b", r, w_frame_done, r == 7); end
    end
    step();
    checks++; if (w_busy !== 1'b0) begin errors++; $display("[TB] FAIL wide_idle got %b want 0", w_busy); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin rom[i] = 8'h00; rom2[i] = 8'h00; end
    test_reset();
    test_basic();
    test_hmirror();
    test_vmirror_yscale();
    test_xscale();
    test_reset_mid_draw();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
